// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: occupancy state encodings and default widths.
package pipe_pkg;

   localparam int unsigned DEF_PC_W   = 32;
   localparam int unsigned DEF_INST_W = 32;
   localparam int unsigned DEF_CNT_W  = 16;

   localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

   // 2'd3 is unused; the FSM recovers from it to EMPTY
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// IF/ID handshake bundle: fetch-side inputs and decode-side outputs.
interface if_id_skid_reg_if #(
   parameter int unsigned MSB    = 32,
   parameter int unsigned INST_W = 32
);
   logic              i_valid;
   logic              o_ready;
   logic [MSB-1:0]    i_next_pc;
   logic [INST_W-1:0] i_inst;
   logic              o_valid;
   logic              i_ready;
   logic [MSB-1:0]    o_next_pc;
   logic [INST_W-1:0] o_inst;

   modport master (
      output i_valid, i_next_pc, i_inst, i_ready,
      input  o_ready, o_valid, o_next_pc, o_inst
   );

   modport slave (
      input  i_valid, i_next_pc, i_inst, i_ready,
      output o_ready, o_valid, o_next_pc, o_inst
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         o_cnt <= '0;
      end else if (i_inc && (o_cnt != {CNT_W{1'b1}})) begin
         o_cnt <= o_cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional performance counters enabled by defining IF_ID_PERF_CNT_EN.
module if_id_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned       MSB      = DEF_PC_W,
   parameter int unsigned       INST_W   = DEF_INST_W,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEF_NOP_INST)
`ifdef IF_ID_PERF_CNT_EN
   ,
   parameter int unsigned       CNT_W    = DEF_CNT_W
`endif
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_flush,
   if_id_skid_reg_if.slave     bus
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]    o_stall_cnt,
   output logic [CNT_W-1:0]    o_flush_cnt
`endif
);

   occ_e              state;
   logic              valid_q;
   logic              ready_q;
   logic [MSB-1:0]    main_pc;
   logic [INST_W-1:0] main_inst;
   logic [MSB-1:0]    skid_pc;
   logic [INST_W-1:0] skid_inst;

   logic in_xfer;
   logic out_xfer;

   assign in_xfer  = bus.i_valid & ready_q;
   assign out_xfer = valid_q & bus.i_ready;

   // Occupancy FSM; o_valid/o_ready are kept as registers beside the state
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         state     <= EMPTY;
         valid_q   <= 1'b0;
         ready_q   <= 1'b1;
         main_pc   <= '0;
         main_inst <= NOP_INST;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_xfer) begin
                  state     <= ONE;
                  valid_q   <= 1'b1;
                  main_pc   <= bus.i_next_pc;
                  main_inst <= bus.i_inst;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  main_pc   <= bus.i_next_pc;
                  main_inst <= bus.i_inst;
               end else if (in_xfer) begin
                  state     <= TWO;
                  ready_q   <= 1'b0;
                  skid_pc   <= bus.i_next_pc;
                  skid_inst <= bus.i_inst;
               end else if (out_xfer) begin
                  state     <= EMPTY;
                  valid_q   <= 1'b0;
                  main_pc   <= '0;
                  main_inst <= NOP_INST;
               end
            end
            TWO: begin
               if (out_xfer) begin
                  state     <= ONE;
                  ready_q   <= 1'b1;
                  main_pc   <= skid_pc;
                  main_inst <= skid_inst;
               end
            end
            default: begin
               state     <= EMPTY;
               valid_q   <= 1'b0;
               ready_q   <= 1'b1;
               main_pc   <= '0;
               main_inst <= NOP_INST;
            end
         endcase
      end
   end

   assign bus.o_valid   = valid_q;
   assign bus.o_ready   = ready_q;
   assign bus.o_next_pc = main_pc;
   assign bus.o_inst    = main_inst;

`ifdef IF_ID_PERF_CNT_EN
   logic stall_inc;
   logic flush_inc;

   assign stall_inc = valid_q & ~bus.i_ready;
   assign flush_inc = i_flush & ~i_rst;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .i_clk (i_clk),
      .i_clr (i_rst),
      .i_inc (stall_inc),
      .o_cnt (o_stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .i_clk (i_clk),
      .i_clr (i_rst),
      .i_inc (flush_inc),
      .o_cnt (o_flush_cnt)
   );
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed self-checking bench for if_id_skid_reg (counter tests when IF_ID_PERF_CNT_EN is defined).
module tb_if_id_skid_reg;
   localparam int unsigned PC_W = 32;
   localparam int unsigned IW   = 32;
   localparam logic [IW-1:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   if_id_skid_reg_if #(.MSB(PC_W), .INST_W(IW)) bus ();

`ifdef IF_ID_PERF_CNT_EN
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;
   logic [1:0]  stall_cnt2;
   logic [1:0]  flush_cnt2;

   if_id_skid_reg_if #(.MSB(PC_W), .INST_W(IW)) bus2 ();
   assign bus2.i_valid   = bus.i_valid;
   assign bus2.i_next_pc = bus.i_next_pc;
   assign bus2.i_inst    = bus.i_inst;
   assign bus2.i_ready   = bus.i_ready;

   if_id_skid_reg #(.MSB(PC_W), .INST_W(IW), .NOP_INST(NOP), .CNT_W(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(bus),
      .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
   );

   if_id_skid_reg #(.MSB(PC_W), .INST_W(IW), .NOP_INST(NOP), .CNT_W(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(bus2),
      .o_stall_cnt(stall_cnt2), .o_flush_cnt(flush_cnt2)
   );
`else
   if_id_skid_reg #(.MSB(PC_W), .INST_W(IW), .NOP_INST(NOP)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(bus)
   );
`endif

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] pc, input logic [31:0] inst);
      bus.i_valid   = 1'b1;
      bus.i_next_pc = pc;
      bus.i_inst    = inst;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; bus.i_ready = 1'b0;
      send(32'd4, 32'd5);
      step(); step();
      n_tests++;
      if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
         n_fail++; $display("FAIL reset_vr: got %b%b expected 01", bus.o_valid, bus.o_ready);
      end
      n_tests++;
      if (bus.o_next_pc !== 32'd0 || bus.o_inst !== NOP) begin
         n_fail++; $display("FAIL reset_data: got %0h/%0h expected 0/%0h", bus.o_next_pc, bus.o_inst, NOP);
      end
      rst = 1'b0;
      step();
      n_tests++;
      if (bus.o_valid !== 1'b1 || bus.o_next_pc !== 32'd4 || bus.o_inst !== 32'd5) begin
         n_fail++; $display("FAIL reset_release: got v=%b %0h/%0h expected v=1 4/5", bus.o_valid, bus.o_next_pc, bus.o_inst);
      end
      bus.i_valid = 1'b0; bus.i_ready = 1'b1;
      step();
   endtask

   task automatic test_streaming();
      bus.i_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         send(32'(4 * (k + 1)), 32'(100 + k));
         step();
         n_tests++;
         if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b1 ||
             bus.o_next_pc !== 32'(4 * (k + 1)) || bus.o_inst !== 32'(100 + k)) begin
            n_fail++;
            $display("FAIL stream_%0d: got v=%b r=%b %0d/%0d expected v=1 r=1 %0d/%0d",
                     k, bus.o_valid, bus.o_ready, bus.o_next_pc, bus.o_inst, 4 * (k + 1), 100 + k);
         end
      end
      bus.i_valid = 1'b0;
      step();
      n_tests++;
      if (bus.o_valid !== 1'b0 || bus.o_inst !== NOP) begin
         n_fail++; $display("FAIL stream_end: got v=%b inst=%0h expected v=0 inst=%0h", bus.o_valid, bus.o_inst, NOP);
      end
   endtask

   task automatic test_back_pressure();
      bus.i_ready = 1'b0;
      send(32'd4, 32'd40); step();
      send(32'd8, 32'd80); step();
      n_tests++;
      if (bus.o_ready !== 1'b0 || bus.o_next_pc !== 32'd4) begin
         n_fail++; $display("FAIL bp_full: got r=%b pc=%0d expected r=0 pc=4", bus.o_ready, bus.o_next_pc);
      end
      send(32'd12, 32'd120); step();
      n_tests++;
      if (bus.o_ready !== 1'b0 || bus.o_next_pc !== 32'd4 || bus.o_inst !== 32'd40) begin
         n_fail++; $display("FAIL bp_hold: got r=%b %0d/%0d expected r=0 4/40", bus.o_ready, bus.o_next_pc, bus.o_inst);
      end
      bus.i_ready = 1'b1;
      step();
      n_tests++;
      if (bus.o_ready !== 1'b1 || bus.o_next_pc !== 32'd8 || bus.o_inst !== 32'd80) begin
         n_fail++; $display("FAIL bp_skid: got r=%b %0d/%0d expected r=1 8/80", bus.o_ready, bus.o_next_pc, bus.o_inst);
      end
      step();
      n_tests++;
      if (bus.o_valid !== 1'b1 || bus.o_next_pc !== 32'd12 || bus.o_inst !== 32'd120) begin
         n_fail++; $display("FAIL bp_third: got v=%b %0d/%0d expected v=1 12/120", bus.o_valid, bus.o_next_pc, bus.o_inst);
      end
      bus.i_valid = 1'b0;
      step();
      n_tests++;
      if (bus.o_valid !== 1'b0 || bus.o_next_pc !== 32'd0) begin
         n_fail++; $display("FAIL bp_drain: got v=%b pc=%0d expected v=0 pc=0", bus.o_valid, bus.o_next_pc);
      end
   endtask

   task automatic test_flush();
      bus.i_ready = 1'b0;
      send(32'd4, 32'd40); step();
      send(32'd8, 32'd80); step();
      flush = 1'b1;
      send(32'd20, 32'd6);
      step();
      flush = 1'b0;
      n_tests++;
      if ({bus.o_valid, bus.o_ready} !== 2'b01 || bus.o_inst !== NOP || bus.o_next_pc !== 32'd0) begin
         n_fail++; $display("FAIL flush: got v=%b r=%b %0d/%0h expected v=0 r=1 0/%0h",
                            bus.o_valid, bus.o_ready, bus.o_next_pc, bus.o_inst, NOP);
      end
      bus.i_valid = 1'b0; bus.i_ready = 1'b1;
      step(); step();
      n_tests++;
      if (bus.o_valid !== 1'b0 || bus.o_next_pc !== 32'd0) begin
         n_fail++; $display("FAIL flush_lost: got v=%b pc=%0d expected v=0 pc=0", bus.o_valid, bus.o_next_pc);
      end
   endtask

   task automatic test_drain();
      bus.i_ready = 1'b0;
      send(32'd8, 32'd80); step();
      n_tests++;
      if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b1 || bus.o_next_pc !== 32'd8) begin
         n_fail++; $display("FAIL drain_one: got v=%b r=%b pc=%0d expected v=1 r=1 pc=8", bus.o_valid, bus.o_ready, bus.o_next_pc);
      end
      bus.i_valid = 1'b0; bus.i_ready = 1'b1;
      step();
      n_tests++;
      if (bus.o_valid !== 1'b0 || bus.o_next_pc !== 32'd0 || bus.o_inst !== NOP) begin
         n_fail++; $display("FAIL drain: got v=%b %0d/%0h expected v=0 0/%0h", bus.o_valid, bus.o_next_pc, bus.o_inst, NOP);
      end
   endtask

   task automatic test_reset_in_two();
      bus.i_ready = 1'b0;
      send(32'd4, 32'd40); step();
      send(32'd8, 32'd80); step();
      rst = 1'b1;
      step();
      rst = 1'b0; bus.i_valid = 1'b0;
      n_tests++;
      if ({bus.o_valid, bus.o_ready} !== 2'b01 || bus.o_next_pc !== 32'd0 || bus.o_inst !== NOP) begin
         n_fail++; $display("FAIL reset_two: got v=%b r=%b %0d/%0h expected v=0 r=1 0/%0h",
                            bus.o_valid, bus.o_ready, bus.o_next_pc, bus.o_inst, NOP);
      end
      bus.i_ready = 1'b1;
      step();
   endtask

`ifdef IF_ID_PERF_CNT_EN
   task automatic test_perf_cnt();
      rst = 1'b1; flush = 1'b1; bus.i_valid = 1'b0; bus.i_ready = 1'b0;
      step();
      n_tests++;
      if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
         n_fail++; $display("FAIL cnt_reset: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
      end
      rst = 1'b0; flush = 1'b0;
      send(32'd4, 32'd40); step();
      bus.i_valid = 1'b0;
      repeat (5) step();
      n_tests++;
      if (stall_cnt !== 16'd5 || stall_cnt2 !== 2'd3) begin
         n_fail++; $display("FAIL stall_cnt: got %0d/%0d expected 5/3", stall_cnt, stall_cnt2);
      end
      step();
      n_tests++;
      if (stall_cnt !== 16'd6 || stall_cnt2 !== 2'd3) begin
         n_fail++; $display("FAIL stall_sat: got %0d/%0d expected 6/3", stall_cnt, stall_cnt2);
      end
      bus.i_ready = 1'b1;
      flush = 1'b1; step();
      flush = 1'b0; step();
      flush = 1'b1; step();
      flush = 1'b0; step();
      n_tests++;
      if (flush_cnt !== 16'd2 || stall_cnt !== 16'd6) begin
         n_fail++; $display("FAIL flush_cnt: got f=%0d s=%0d expected f=2 s=6", flush_cnt, stall_cnt);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; flush = 1'b0;
      bus.i_valid = 1'b0; bus.i_next_pc = '0; bus.i_inst = '0; bus.i_ready = 1'b0;
      test_reset();
      test_streaming();
      test_back_pressure();
      test_flush();
      test_drain();
      test_reset_in_two();
`ifdef IF_ID_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
